// File: rtl/tl_ul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_ul_pkg : shared opcodes, response entry and lane helper for TL-UL |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package tl_ul_pkg;

    localparam int DATA_W       = 32;
    localparam int MASK_W       = DATA_W / 8;
    localparam int SIZE_MAX_W   = 4;
    localparam int SOURCE_MAX_W = 8;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4
    } a_opcode_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } d_opcode_e;

    // Fields are sized for the widest configuration; the top narrows them on output.
    typedef struct packed {
        d_opcode_e                opcode;
        logic [SIZE_MAX_W-1:0]    size;
        logic [SOURCE_MAX_W-1:0]  source;
        logic                     denied;
        logic [DATA_W-1:0]        data;
    } resp_t;

    function automatic logic [MASK_W-1:0] size_to_mask(input logic [1:0] lg_size,
                                                       input logic [1:0] addr_lo);
        logic [MASK_W-1:0] m;
        case (lg_size)
            2'd0:    m = 4'b0001 << addr_lo;
            2'd1:    m = 4'b0011 << {addr_lo[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_ul_resp_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_ul_resp_queue : circular FIFO of D-channel responses              |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tl_ul_resp_queue
    import tl_ul_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push_valid,
    output logic  push_ready,
    input  resp_t push_data,
    output logic  pop_valid,
    input  logic  pop_ready,
    output resp_t pop_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    resp_t            entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign pop_valid  = (count != '0);
    // A full queue still accepts when the head leaves in the same cycle.
    assign push_ready = (count != FULL) | pop_ready;
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign pop_data   = entries[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) entries[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/tl_ul_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_ul_mem_responder : TL-UL manager serving Get/Put from scratch RAM |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module tl_ul_mem_responder
    import tl_ul_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int SOURCE_W = 3,
    parameter int SIZE_W   = 2,
    parameter int QDEPTH   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [SIZE_W-1:0]   d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_denied,
    output logic                d_corrupt,
    output logic [31:0]         d_data
);

    localparam int WORDS = 1 << (ADDR_W - 2);

    logic [DATA_W-1:0] mem [WORDS];
    logic [ADDR_W-3:0] idx;
    logic              a_fire;
    logic              is_get;
    logic              is_put;
    logic              size_ok;
    logic              align_ok;
    logic              mask_ok;
    logic              legal;
    logic              mem_we;
    logic [1:0]        align_bits;
    logic [MASK_W-1:0] full_mask;
    logic              push_ready;
    logic              head_valid;
    resp_t             push_entry;
    resp_t             head;
    logic              unused_bits;

    assign idx        = a_address[ADDR_W-1:2];
    assign is_get     = (a_opcode == GET);
    assign is_put     = (a_opcode == PUT_FULL) | (a_opcode == PUT_PARTIAL);
    assign size_ok    = (a_size <= SIZE_W'(2));
    assign align_bits = (a_size[1:0] == 2'd0) ? 2'b00 :
                        (a_size[1:0] == 2'd1) ? 2'b01 : 2'b11;
    assign align_ok   = ((a_address[1:0] & align_bits) == 2'b00);
    assign full_mask  = size_to_mask(a_size[1:0], a_address[1:0]);
    assign mask_ok    = (a_opcode != PUT_FULL) | (a_mask == full_mask);
    assign legal      = (is_get | is_put) & size_ok & align_ok & mask_ok;

    assign a_ready    = push_ready;
    assign a_fire     = a_valid & a_ready;
    // An accept coinciding with reset must leave memory untouched.
    assign mem_we     = a_fire & is_put & legal & ~reset;

    always_comb begin
        push_entry        = '0;
        push_entry.opcode = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        push_entry.size   = SIZE_MAX_W'(a_size);
        push_entry.source = SOURCE_MAX_W'(a_source);
        push_entry.denied = ~legal;
        push_entry.data   = (is_get & legal) ? mem[idx] : '0;
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    tl_ul_resp_queue #(
        .DEPTH (QDEPTH)
    ) u_resp_queue (
        .clock      (clock),
        .reset      (reset),
        .push_valid (a_valid),
        .push_ready (push_ready),
        .push_data  (push_entry),
        .pop_valid  (head_valid),
        .pop_ready  (d_ready),
        .pop_data   (head)
    );

    // Queue storage is not reset, so every field is masked while empty.
    assign d_valid   = head_valid;
    assign d_opcode  = head_valid ? head.opcode : ACCESS_ACK;
    assign d_param   = 2'b00;
    assign d_size    = head_valid ? head.size[SIZE_W-1:0] : '0;
    assign d_source  = head_valid ? head.source[SOURCE_W-1:0] : '0;
    assign d_denied  = head_valid & head.denied;
    assign d_corrupt = head_valid & head.denied & (head.opcode == ACCESS_ACK_DATA);
    assign d_data    = head_valid ? head.data : '0;

    assign unused_bits = ^{a_param, head.size, head.source};

endmodule
`default_nettype wire

// File: doc/tl_ul_mem_responder.md
Name: tl_ul_mem_responder

Overview:
- TileLink-UL responder (manager end) for the client A/D link checked by the existing TL protocol monitors.
- Accepts single-beat Get, PutFullData and PutPartialData requests on channel A and services them against a local word-addressed scratch memory.
- Returns AccessAckData or AccessAck on channel D, in request order.
- Sits behind a crossbar port so the monitor can be bound to its A/D pins unchanged.

Parameters:
- ADDR_W, 9, A-channel address width in bytes.
- SOURCE_W, 3, source ID width.
- SIZE_W, 2, lg2 size field width.
- QDEPTH, 2, response queue entries (power of two, >=1).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  A-channel request valid.
- a_ready  out  1  A-channel ready.
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get; others illegal.
- a_param  in  3  must be 0; ignored for function.
- a_size  in  SIZE_W  lg2 bytes (0..2 legal).
- a_source  in  SOURCE_W  request ID.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- d_valid  out  1  D-channel response valid.
- d_ready  in  1  D-channel ready.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  SIZE_W  echo of a_size.
- d_source  out  SOURCE_W  echo of a_source.
- d_denied  out  1  request refused.
- d_corrupt  out  1  equals d_denied on AccessAckData, otherwise 0.
- d_data  out  32  read data; 0 when denied or AccessAck.

Behaviour:
- Memory: 2^(ADDR_W-2) x 32-bit words, index = a_address[ADDR_W-1:2]. Memory is not reset.
- Accept: a request is accepted when a_fire = a_valid & a_ready.
- Ready: a_ready = (count != QDEPTH) | d_ready. Accepting while full is allowed only when the head is popped in the same cycle.
- Legality: a request is illegal if any of the following holds:
  - opcode not in {0,1,4};
  - a_size > 2;
  - a_address & ((1<<a_size)-1) != 0;
  - PutFullData mask does not match the size/address lanes.
- Illegal request: memory untouched; response enqueued with d_denied=1. d_opcode=1 for Get, 0 otherwise.
- Put (legal): on a_fire, write bytes where a_mask[i]=1. Enqueue AccessAck.
- Get (legal): on a_fire, read the addressed word combinationally from the pre-write array. Enqueue AccessAckData with the full word; the client selects lanes.
- Same-cycle collision: if a Put is accepted in cycle N, a Get accepted in cycle N+1 returns the new data.
- Queue: entries hold {opcode, size, source, denied, data}. FIFO order, with wrap-around pointers and a count register.
- Latency: d_valid rises in the cycle after a_fire at the earliest (1-cycle latency). There is no combinational A->D path.
- D-channel stability: d_valid = (count != 0). D outputs come from the head entry and hold stable while d_valid & ~d_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Reset (async assert, sync release): count=0, pointers=0, d_valid=0, a_ready=1. All other D outputs=0.
- Reset mid-transaction: queued responses are discarded and memory contents are retained. Reset taking effect within the same cycle as a_fire produces no write.
- a_param != 0: treated as legal (monitor flags it); no functional effect.

Decomposition:
- Package tl_ul_pkg holds:
  - opcode enums (A: PUT_FULL=0, PUT_PARTIAL=1, GET=4; D: ACCESS_ACK=0, ACCESS_ACK_DATA=1);
  - the response-entry struct typedef;
  - the size-to-mask function.
- Sub-module tl_ul_resp_queue: parameterised FIFO with valid/ready on both sides. The top module holds the decode, legality check and memory.

Test Plan:
- Reset, then PutFull addr 0x010, size 2, mask 0xF, data 0xDEADBEEF, source 3 -> next cycle d_valid=1, d_opcode=0, d_source=3, d_denied=0.
- Get addr 0x010, size 2, source 5 issued the cycle after the Put -> AccessAckData, d_data=0xDEADBEEF, d_source=5, d_corrupt=0.
- PutPartial addr 0x010, mask 0x2, data 0x0000AA00, then Get -> d_data=0xDEADAAEF.
- Misaligned Get addr 0x012, size 2 -> d_opcode=1, d_denied=1, d_corrupt=1, d_data=0. Opcode 2 -> d_opcode=0, d_denied=1, memory unchanged.
- Backpressure: d_ready=0, issue 3 Gets -> a_ready=0 after 2 accepts and D outputs stable. Raise d_ready for 1 cycle -> third Get accepted in that same cycle. Responses return in source order 1,2,3.
- Assert reset while 2 responses are queued -> d_valid=0 immediately. After release, Get addr 0x010 still returns 0xDEADAAEF.
